uart_rx_core: RTL
=================

# uart_rx_core

UART receive stage that consumes the oversampling tick produced by the baud-rate timer (timer configured to pulse `s_tick` at 16x the baud rate) and deserialises the asynchronous `rx` line into parallel data words. It handles start-bit validation, LSB-first data capture, stop-bit checking and a one-cycle completion strobe. Its outputs feed the receive FIFO or interface logic downstream.

## Interface
- `DBIT`, default 8: data bits per frame; legal range 5..9.
- `SB_TICK`, default 16: stop-bit duration in `s_tick` units; legal values are 16, 24 and 32 (1, 1.5 and 2 stop bits).
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `s_tick` input 1: oversampling enable from the baud timer; one `clk`-wide pulse, 16 per bit period.
- `rx` input 1: asynchronous serial line; idles high.
- `rx_dout` output DBIT: last received word, LSB = first data bit received.
- `rx_done_tick` output 1: one-`clk` pulse marking that a frame has completed.
- `frame_err` output 1: stop-bit error flag for the last completed frame.

## Operation
- **Input synchroniser.** `rx` passes through a 2-flop synchroniser, producing `rx_s`. Both flops reset to 1. The FSM sees only `rx_s`.
- **Registers.**
  - `state`: IDLE, START, DATA, STOP.
  - `s`: 5-bit tick counter.
  - `n`: data-bit counter, width clog2(DBIT), minimum 1.
  - `b`: DBIT-bit shift register.
- **Counter gating.** Counters and the shift register change only on cycles where `s_tick`=1. The single exception is the IDLE -> START transition.
- **IDLE.**
  - When `rx_s`=0: go to START and set `s`=0. This transition does not wait for a tick.
  - Otherwise stay in IDLE.
- **START**, on each tick:
  - If `s`==7 (mid start bit) and `rx_s`=0: go to DATA, set `s`=0 and `n`=0.
  - If `s`==7 and `rx_s`=1: treat as a glitch and return to IDLE with no output.
  - Otherwise `s`++.
- **DATA**, on each tick:
  - If `s`==15: set `s`=0 and shift `b` <= {`rx_s`, `b`[DBIT-1:1]}. Then, if `n`==DBIT-1, go to STOP; otherwise `n`++.
  - Otherwise `s`++.
- **STOP**, on each tick:
  - If `s`==SB_TICK-1: load `rx_dout` <= `b`, `frame_err` <= ~`rx_s`, pulse `rx_done_tick`, and return to IDLE.
  - Otherwise `s`++.
- **Data sampling.** Each data bit is sampled once, at mid-bit. The stop bit is sampled once, at the end of the SB_TICK window. There is no majority voting.
- **Output holding.** `rx_dout` and `frame_err` hold their values until the next frame completes. A frame with a framing error still updates `rx_dout`.
- **Activity during STOP.** Edges on `rx` during STOP are ignored until the final stop sample.

## Timing
- **Reset values.** `rst`=1 at a clock edge forces:
  - state IDLE;
  - `s`=0, `n`=0, `b`=0;
  - `rx_dout`=0, `rx_done_tick`=0, `frame_err`=0;
  - synchroniser flops = 1.
- **Reset mid-frame.** Reset asserted mid-frame aborts the frame and produces no done pulse. Reset has priority over every other event.
- **Output registration.** `rx_done_tick`, `rx_dout` and `frame_err` are registered. All three update on the clock edge that consumes the final stop tick, and are visible in the following cycle. `rx_done_tick` is high for exactly one `clk` cycle.
- **Frame latency.** From the cycle `rx_s` first reads 0 to the final stop tick takes 8 + 16*DBIT + SB_TICK ticks. With defaults that is 152 ticks. The `rx` pin adds 2 `clk` of synchroniser latency on top of this.
- **Back-to-back frames.** The final stop sample falls at mid stop bit, leaving half a bit of margin. A start bit that immediately follows the stop bit is therefore detected with no idle gap required.
- **No ticks.** With `s_tick` held at 0, the FSM can leave IDLE but never advances past START.
- **Counter range.** `s` never exceeds 31, and there is no wrap-around: each state clears `s` on exit.

## Test plan
- **Nominal frame.** Timer drives `s_tick` every 4 `clk`. Send 0xA5 at 64 clk/bit with 1 stop bit. Required: exactly one `rx_done_tick` pulse, `rx_dout`=0xA5, `frame_err`=0. The pulse occurs 152 ticks after the start edge, plus 2 clk.
- **Start-bit glitch.** Drive `rx` low for 4 ticks, then high. Required: FSM returns to IDLE, no `rx_done_tick`, and `rx_dout` keeps its previous value.
- **Framing error.** Send 0x3C with `rx`=0 during the stop bit. Required: one done pulse, `rx_dout`=0x3C, `frame_err`=1. A following good frame 0x81 gives `frame_err`=0.
- **Back-to-back frames.** Send 0x00 then 0xFF with no idle gap. Required: two done pulses, `rx_dout`=0x00 then 0xFF.
- **Reset mid-frame.** Assert `rst` for 1 clk during the 4th data bit. Required: next cycle state IDLE and all outputs 0, with no done pulse. A subsequent frame 0x55 is received correctly.
- **Parameter variant.** DBIT=7, SB_TICK=32. Send 0x6A (7 bits). Required: `rx_dout`=0x6A with the done pulse after 8 + 112 + 32 = 152 ticks.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receive core: 2-flop synchroniser plus a 16x-oversampled start/data/stop FSM.
// Emits the received word, a stop-bit error flag and a one-clock completion strobe.
module uart_rx_core #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done_tick,
   output logic            frame_err
);

   localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [NW-1:0] NLast = NW'(DBIT - 1);
   localparam logic [4:0]    SLast = 5'(SB_TICK - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [4:0]        s_q, s_d;
   logic [NW-1:0]     n_q, n_d;
   logic [DBIT-1:0]   b_q, b_d;
   logic [DBIT-1:0]   dout_q, dout_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;
   logic              rx_meta_q, rx_s_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         s_q       <= '0;
         n_q       <= '0;
         b_q       <= '0;
         dout_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         s_q       <= s_d;
         n_q       <= n_d;
         b_q       <= b_d;
         dout_q    <= dout_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
      unique case (state_q)
         StIdle: begin
            // Start edge is taken immediately so the mid-start count begins from the edge.
            if (!rx_s_q) begin
               state_d = StStart;
               s_d     = '0;
            end
         end
         StStart: begin
            if (s_tick) begin
               if (s_q == 5'd7) begin
                  s_d = '0;
                  if (!rx_s_q) begin
                     state_d = StData;
                     n_d     = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StData: begin
            if (s_tick) begin
               if (s_q == 5'd15) begin
                  s_d = '0;
                  b_d = {rx_s_q, b_q[DBIT-1:1]};
                  if (n_q == NLast) begin
                     state_d = StStop;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StStop: begin
            if (s_tick) begin
               if (s_q == SLast) begin
                  s_d     = '0;
                  state_d = StIdle;
                  dout_d  = b_q;
                  ferr_d  = ~rx_s_q;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rx_dout      = dout_q;
   assign rx_done_tick = done_q;
   assign frame_err    = ferr_q;

endmodule
